// File: rtl/mem_arbiter_ctrl_if.sv
// Signal bundle shared by the two requesters, the arbiter/controller and the
// asynchronous scratch memory. The controller uses the slave view; the
// requesters together with the memory use the master view.
interface mem_arbiter_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          done0, done1;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_cs, mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata, err,
           mem_cs, mem_wr, mem_rd, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata, err,
           mem_cs, mem_wr, mem_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Two-port round-robin controller for the small asynchronous scratch memory.
// Each access runs SETUP -> STROBE -> HOLD so address/data are stable around
// the wr/rd strobe; all outputs are registered.
// Optional feature macro: ADDR_CHECK_EN -- rejects addresses >= DEPTH without
// touching the memory and flags the completion with err.
//
// state  | meaning
// IDLE   | no access; done pulse of the previous access; arbitration
// SETUP  | gnt pulse; cs, address and write data presented, no strobe
// STROBE | wr or rd strobe asserted
// HOLD   | wr released, rd kept high; read data captured on exit
module mem_arbiter_ctrl #(
  parameter int AW    = 4,
  parameter int DW    = 4,
  parameter int DEPTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_ctrl_if.slave bus
);

`ifdef ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_nx;
  logic          rr_ptr, rr_nx;
  logic          win, win_nx;
  logic          we_q, we_nx;
  logic          rej, rej_nx;
  logic          gnt0_nx, gnt1_nx, done0_nx, done1_nx, err_nx;
  logic          cs_nx, wr_nx, rd_nx;
  logic [AW-1:0] addr_nx;
  logic [DW-1:0] wdata_nx, rdata_nx;
  logic          pick, pick_we;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  // Round-robin winner and its request fields; rr_ptr only matters on a tie.
  always_comb begin
    pick       = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
    pick_we    = pick ? bus.we1    : bus.we0;
    pick_addr  = pick ? bus.addr1  : bus.addr0;
    pick_wdata = pick ? bus.wdata1 : bus.wdata0;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    win_nx   = win;
    we_nx    = we_q;
    rej_nx   = rej;
    gnt0_nx  = 1'b0;
    gnt1_nx  = 1'b0;
    done0_nx = 1'b0;
    done1_nx = 1'b0;
    err_nx   = 1'b0;
    cs_nx    = 1'b0;
    wr_nx    = 1'b0;
    rd_nx    = 1'b0;
    addr_nx  = bus.mem_addr;
    wdata_nx = bus.mem_wdata;
    rdata_nx = bus.rdata;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nx = SETUP;
          rr_nx    = ~pick;
          win_nx   = pick;
          we_nx    = pick_we;
          rej_nx   = CHECK_EN && (int'(pick_addr) >= DEPTH);
          gnt0_nx  = ~pick;
          gnt1_nx  = pick;
          // A rejected access leaves the memory bus completely untouched.
          if (!rej_nx) begin
            cs_nx    = 1'b1;
            addr_nx  = pick_addr;
            wdata_nx = pick_wdata;
          end
        end
      end
      SETUP: begin
        if (rej) begin
          state_nx = IDLE;
          done0_nx = ~win;
          done1_nx = win;
          err_nx   = 1'b1;
        end else begin
          state_nx = STROBE;
          cs_nx    = 1'b1;
          wr_nx    = we_q;
          rd_nx    = ~we_q;
        end
      end
      STROBE: begin
        state_nx = HOLD;
        cs_nx    = 1'b1;
        rd_nx    = ~we_q;
      end
      HOLD: begin
        state_nx = IDLE;
        done0_nx = ~win;
        done1_nx = win;
        if (!we_q) rdata_nx = bus.mem_rdata;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= 1'b0;
      win           <= 1'b0;
      we_q          <= 1'b0;
      rej           <= 1'b0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.done0     <= 1'b0;
      bus.done1     <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata     <= '0;
      bus.mem_cs    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_nx;
      rr_ptr        <= rr_nx;
      win           <= win_nx;
      we_q          <= we_nx;
      rej           <= rej_nx;
      bus.gnt0      <= gnt0_nx;
      bus.gnt1      <= gnt1_nx;
      bus.done0     <= done0_nx;
      bus.done1     <= done1_nx;
      bus.err       <= err_nx;
      bus.rdata     <= rdata_nx;
      bus.mem_cs    <= cs_nx;
      bus.mem_wr    <= wr_nx;
      bus.mem_rd    <= rd_nx;
      bus.mem_addr  <= addr_nx;
      bus.mem_wdata <= wdata_nx;
    end
  end

endmodule
